// File: rtl/imu_sync_pkg.sv
// Shared types for the IMU sync path: FIFO word layout, response status codes
// and the bracket-fetch FSM states.
package imu_sync_pkg;

  localparam int WORD_W = 64;
  localparam int TS_W   = 32;
  localparam int TS_MSB = WORD_W - 1;
  localparam int TS_LSB = WORD_W - TS_W;

  typedef logic [WORD_W-1:0] imu_word_t;
  typedef logic [TS_W-1:0]   imu_ts_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_STALE   = 2'd1,
    ST_TIMEOUT = 2'd2
  } rsp_status_e;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    POP,
    WAIT,
    RESP
  } bf_state_e;

  function automatic imu_ts_t word_ts(input imu_word_t w);
    return w[TS_MSB:TS_LSB];
  endfunction

endpackage

// File: rtl/imu_bracket_fetch_if.sv
// Bundles the FIFO pop port, the query request and the bracket response.
// master = the bracket fetcher, slave = the surrounding FIFO / scheduler / interpolator.
interface imu_bracket_fetch_if #(
  parameter int WIDTH = 64,
  parameter int TS_W  = 32
);

  logic             fifo_read_en;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;

  logic             req_valid;
  logic             req_ready;
  logic [TS_W-1:0]  req_ts;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_older;
  logic [WIDTH-1:0] rsp_newer;
  logic [1:0]       rsp_status;

  modport master (
    output fifo_read_en,
    input  fifo_data,
    input  fifo_empty,
    input  req_valid,
    output req_ready,
    input  req_ts,
    output rsp_valid,
    input  rsp_ready,
    output rsp_older,
    output rsp_newer,
    output rsp_status
  );

  modport slave (
    input  fifo_read_en,
    output fifo_data,
    output fifo_empty,
    output req_valid,
    input  req_ready,
    output req_ts,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_older,
    input  rsp_newer,
    input  rsp_status
  );

endinterface

// File: rtl/imu_ts_ge.sv
// Wrap-aware timestamp compare: a is at or after b when (a - b) mod 2^TS_W,
// read as signed, is non-negative.
module imu_ts_ge #(
  parameter int TS_W = 32
) (
  input  logic [TS_W-1:0] a,
  input  logic [TS_W-1:0] b,
  output logic            a_ge_b
);

  logic [TS_W-1:0] diff;

  assign diff   = a - b;
  assign a_ge_b = ~diff[TS_W-1];

endmodule

// File: rtl/imu_bracket_fetch.sv
// Pops IMU samples from the buffer FIFO until the held pair {A, B} brackets the
// query timestamp, then returns both samples with an OK / STALE / TIMEOUT status.
module imu_bracket_fetch #(
  parameter int WIDTH       = 64,
  parameter int TS_W        = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  imu_bracket_fetch_if.master bus
);

  import imu_sync_pkg::*;

  localparam int              TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  bf_state_e        state_q;
  bf_state_e        state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             a_vld_q;
  logic             b_vld_q;
  logic [TS_W-1:0]  q_ts_q;
  logic [TMO_W-1:0] tmo_q;
  rsp_status_e      status_q;

  logic             b_ge_q;
  logic             q_ge_a;
  logic             hit;
  logic             tmo_hit;

  imu_ts_ge #(.TS_W(TS_W)) u_b_ge_q (
    .a      (b_q[WIDTH-1 -: TS_W]),
    .b      (q_ts_q),
    .a_ge_b (b_ge_q)
  );

  imu_ts_ge #(.TS_W(TS_W)) u_q_ge_a (
    .a      (q_ts_q),
    .b      (a_q[WIDTH-1 -: TS_W]),
    .a_ge_b (q_ge_a)
  );

  assign hit     = b_vld_q & b_ge_q;
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = CHECK;
      CHECK:   state_d = hit ? RESP : POP;
      POP: begin
        if (!bus.fifo_empty) state_d = WAIT;
        else if (tmo_hit)    state_d = RESP;
      end
      WAIT:    state_d = CHECK;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response fields are only driven in RESP; an invalid slot always reads as zero.
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.fifo_read_en = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_older    = '0;
    bus.rsp_newer    = '0;
    bus.rsp_status   = ST_OK;
    case (state_q)
      IDLE: bus.req_ready    = 1'b1;
      POP:  bus.fifo_read_en = ~bus.fifo_empty;
      RESP: begin
        bus.rsp_valid  = 1'b1;
        bus.rsp_older  = a_vld_q ? a_q : '0;
        bus.rsp_newer  = b_vld_q ? b_q : '0;
        bus.rsp_status = status_q;
      end
      default: ;
    endcase
  end

  // A and B survive across queries since queries arrive in time order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      q_ts_q   <= '0;
      tmo_q    <= '0;
      status_q <= ST_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            q_ts_q <= bus.req_ts;
            tmo_q  <= '0;
          end
        end
        CHECK: begin
          if (hit) begin
            status_q <= (a_vld_q & q_ge_a) ? ST_OK : ST_STALE;
          end
        end
        POP: begin
          if (!bus.fifo_empty) begin
            tmo_q <= '0;
          end else if (tmo_hit) begin
            status_q <= ST_TIMEOUT;
            tmo_q    <= '0;
            q_ts_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        WAIT: begin
          a_q     <= b_q;
          a_vld_q <= b_vld_q;
          b_q     <= bus.fifo_data;
          b_vld_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_bracket_fetch.sv
// Scenario bench for imu_bracket_fetch: behavioural FIFO, scoreboard of expected
// responses, one task per scenario.
module tb_imu_bracket_fetch;

  import imu_sync_pkg::*;

  localparam int TMO = 8;

  typedef struct {
    logic [63:0] older;
    logic [63:0] newer;
    logic [1:0]  status;
    int          lat;
    int          pops;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  logic [63:0] mem [0:63];
  int          wr_ptr     = 0;
  int          rd_ptr     = 0;
  logic [63:0] fifo_word  = '0;
  int          pop_count  = 0;
  int          viol_count = 0;

  imu_bracket_fetch_if #(.WIDTH(64), .TS_W(32)) bus ();

  imu_bracket_fetch #(
    .WIDTH       (64),
    .TS_W        (32),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_data  = fifo_word;

  // Registered-output FIFO model: popped word appears the cycle after the pop.
  always @(posedge clk) begin
    if (bus.fifo_read_en) begin
      pop_count <= pop_count + 1;
      if (wr_ptr == rd_ptr) begin
        viol_count <= viol_count + 1;
      end else begin
        fifo_word <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  function automatic logic [63:0] mk(input logic [31:0] ts);
    return {ts, ts ^ 32'h5A5A_5A5A};
  endfunction

  task automatic push(input logic [31:0] ts);
    mem[wr_ptr] = mk(ts);
    wr_ptr++;
  endtask

  task automatic send_query(input logic [31:0] ts, output logic acc);
    acc           = 1'b0;
    bus.req_ts    = ts;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic got, output int lat, output logic [63:0] older,
                          output logic [63:0] newer, output logic [1:0] st);
    got = 1'b0; lat = 0; older = '0; newer = '0; st = '0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got   = 1'b1;
        lat   = i;
        older = bus.rsp_older;
        newer = bus.rsp_newer;
        st    = bus.rsp_status;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_ts    = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    checks++;
    if ({bus.fifo_read_en, bus.rsp_valid, bus.rsp_status, bus.rsp_older, bus.rsp_newer} !== '0)
      begin errors++; $display("[TB] FAIL reset_outputs: rd=%b vld=%b st=%0d older=%h newer=%h expected all 0",
        bus.fifo_read_en, bus.rsp_valid, bus.rsp_status, bus.rsp_older, bus.rsp_newer); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_release: req_ready=%b rsp_valid=%b expected 1/0",
        bus.req_ready, bus.rsp_valid); end
  endtask

  // Generic query scenario: scoreboard entry pushed at drive time, popped at response.
  task automatic test_query(input string name, input logic [31:0] q, input exp_t e);
    logic acc, got; int lat, p0; logic [63:0] older, newer; logic [1:0] st; exp_t x;
    sb.push_back(e);
    p0 = pop_count;
    send_query(q, acc);
    wait_rsp(got, lat, older, newer, st);
    x = sb.pop_front();
    checks++;
    if (!acc || !got)
      begin errors++; $display("[TB] FAIL %s_handshake: accepted=%b responded=%b expected 1/1", name, acc, got); end
    checks++;
    if (st !== x.status)
      begin errors++; $display("[TB] FAIL %s_status: got %0d expected %0d", name, st, x.status); end
    checks++;
    if (older !== x.older)
      begin errors++; $display("[TB] FAIL %s_older: got %h expected %h", name, older, x.older); end
    checks++;
    if (newer !== x.newer)
      begin errors++; $display("[TB] FAIL %s_newer: got %h expected %h", name, newer, x.newer); end
    checks++;
    if (lat !== x.lat)
      begin errors++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, x.lat); end
    checks++;
    if ((pop_count - p0) !== x.pops)
      begin errors++; $display("[TB] FAIL %s_pops: got %0d expected %0d", name, pop_count - p0, x.pops); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL %s_return_idle: rsp_valid=%b req_ready=%b expected 0/1",
        name, bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_cold_start();
    push(32'd100); push(32'd200); push(32'd300);
    test_query("cold", 32'd250, '{mk(32'd200), mk(32'd300), ST_OK, 11, 3});
  endtask

  task automatic test_reuse();
    test_query("reuse", 32'd260, '{mk(32'd200), mk(32'd300), ST_OK, 2, 0});
  endtask

  task automatic test_stale();
    test_query("stale", 32'd150, '{mk(32'd200), mk(32'd300), ST_STALE, 2, 0});
  endtask

  task automatic test_timeout();
    test_query("timeout", 32'd400, '{mk(32'd200), mk(32'd300), ST_TIMEOUT, 2 + TMO, 0});
  endtask

  task automatic test_backpressure();
    logic acc, got; int lat; logic [63:0] older, newer; logic [1:0] st; exp_t x;
    bus.rsp_ready = 1'b0;
    sb.push_back('{mk(32'd200), mk(32'd300), ST_OK, 2, 0});
    send_query(32'd300, acc);
    wait_rsp(got, lat, older, newer, st);
    x = sb.pop_front();
    checks++;
    if (!got || st !== x.status || older !== x.older || newer !== x.newer)
      begin errors++; $display("[TB] FAIL bp_first: got=%b st=%0d older=%h newer=%h expected st=%0d older=%h newer=%h",
        got, st, older, newer, x.status, x.older, x.newer); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== x.status ||
          bus.rsp_older !== x.older || bus.rsp_newer !== x.newer)
        begin errors++; $display("[TB] FAIL bp_hold%0d: vld=%b st=%0d older=%h newer=%h expected 1/%0d/%h/%h",
          i, bus.rsp_valid, bus.rsp_status, bus.rsp_older, bus.rsp_newer, x.status, x.older, x.newer); end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL bp_release: rsp_valid=%b req_ready=%b expected 0/1",
        bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_reset_in_wait();
    logic acc, found; int p0;
    push(32'd500);
    p0    = pop_count;
    found = 1'b0;
    send_query(32'd500, acc);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.fifo_read_en) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!acc || !found)
      begin errors++; $display("[TB] FAIL rstwait_pop: accepted=%b pop_seen=%b expected 1/1", acc, found); end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.fifo_read_en, bus.rsp_valid, bus.rsp_status, bus.rsp_older, bus.rsp_newer} !== '0 ||
        bus.req_ready !== 1'b1)
      begin errors++; $display("[TB] FAIL rstwait_async: rd=%b vld=%b st=%0d older=%h newer=%h rdy=%b expected 0s, rdy 1",
        bus.fifo_read_en, bus.rsp_valid, bus.rsp_status, bus.rsp_older, bus.rsp_newer, bus.req_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || (pop_count - p0) !== 1)
      begin errors++; $display("[TB] FAIL rstwait_after: req_ready=%b rsp_valid=%b pops=%0d expected 1/0/1",
        bus.req_ready, bus.rsp_valid, pop_count - p0); end
  endtask

  task automatic test_wrap();
    push(32'hFFFF_FFF0); push(32'h0000_0010);
    test_query("wrap", 32'h0000_0000, '{mk(32'hFFFF_FFF0), mk(32'h0000_0010), ST_OK, 8, 2});
  endtask

  task automatic test_protocol();
    checks++;
    if (viol_count !== 0)
      begin errors++; $display("[TB] FAIL pop_while_empty: got %0d expected 0", viol_count); end
    checks++;
    if (sb.size() !== 0)
      begin errors++; $display("[TB] FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_reuse();
    test_stale();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_wrap();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
